hazard_ctrl_unit: RTL and testbench

- Parametrised, stateful hazard/forwarding controller for the 5-stage RISC-V core. It generalises the ID-stage hazard logic with:
  - configurable load-use stall depth;
  - variable-latency data-memory wait with timeout;
  - taken-branch flush from EXE;
  - load-to-store data forwarding.
- Sits beside the pipeline registers. Drives PC enable, the IF/ID, ID/EX, EX/MEM and MEM/WB enable/flush controls, and the ALU-operand forwarding muxes.

---
 rtl/hazard_pkg.sv | 29 ++
 rtl/fwd_select.sv | 40 ++++
 rtl/hazard_ctrl_unit.sv | 206 ++++++++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/forwarding controller: op classes, forward selects, FSM states.
package hazard_pkg;

  typedef enum logic [1:0] {
    OP_NONE   = 2'b00,
    OP_ALU    = 2'b01,
    OP_LOAD   = 2'b10,
    OP_BRANCH = 2'b11
  } optype_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EXE = 2'b01,
    FWD_MEM = 2'b10,
    FWD_LD  = 2'b11
  } fwd_e;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_LU_STALL = 2'b01,
    ST_MEM_WAIT = 2'b10,
    ST_ERR      = 2'b11
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Per-operand forwarding select: EXE ALU beats MEM ALU beats MEM load; x0 never matches.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_rs,
  input  logic              i_use,
  input  logic [REG_AW-1:0] i_rd_exe,
  input  logic [1:0]        i_op_exe,
  input  logic [REG_AW-1:0] i_rd_mem,
  input  logic [1:0]        i_op_mem,
  output logic [1:0]        o_sel,
  output logic              o_exe_load_hit
);

  logic w_src_live;
  logic w_hit_exe;
  logic w_hit_mem;

  assign w_src_live = i_use && (i_rs != {REG_AW{1'b0}});
  assign w_hit_exe  = w_src_live && (i_rs == i_rd_exe);
  assign w_hit_mem  = w_src_live && (i_rs == i_rd_mem);

  // Priority select of the youngest producer; an EXE load cannot forward, it stalls instead.
  always_comb begin
    o_sel          = FWD_RF;
    o_exe_load_hit = w_hit_exe && (i_op_exe == OP_LOAD);
    if (w_hit_exe && (i_op_exe == OP_ALU)) begin
      o_sel = FWD_EXE;
    end else if (w_hit_mem && (i_op_mem == OP_ALU)) begin
      o_sel = FWD_MEM;
    end else if (w_hit_mem && (i_op_mem == OP_LOAD)) begin
      o_sel = FWD_LD;
    end else begin
      o_sel = FWD_RF;
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard/forwarding controller for the 5-stage core: load-use stall, memory wait with timeout,
// branch flush, forwarding. Define HAZ_PERF_CNT_EN to add saturating stall/flush counters.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int LU_STALL_CYC = 1,
  parameter int MEM_TIMEOUT  = 15,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1_ID,
  input  logic [REG_AW-1:0] rs2_ID,
  input  logic              rs1use_ID,
  input  logic              rs2use_ID,
  input  logic [1:0]        hazard_optype_ID,
  input  logic [1:0]        hazard_optype_EXE,
  input  logic [1:0]        hazard_optype_MEM,
  input  logic [REG_AW-1:0] rd_EXE,
  input  logic [REG_AW-1:0] rd_MEM,
  input  logic [REG_AW-1:0] rs2_EXE,
  input  logic              store_EXE,
  input  logic              branch_taken_EXE,
  input  logic              mem_ready,
  output logic              PC_EN_IF,
  output logic              reg_FD_EN,
  output logic              reg_DE_EN,
  output logic              reg_EM_EN,
  output logic              reg_MW_EN,
  output logic              reg_FD_flush,
  output logic              reg_DE_flush,
  output logic              reg_EM_flush,
  output logic [1:0]        forward_ctrl_A,
  output logic [1:0]        forward_ctrl_B,
  output logic              forward_ctrl_ls,
  output logic              mem_err
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  localparam int unsigned WAIT_MAX = max_u(MEM_TIMEOUT, LU_STALL_CYC);
  localparam int          CW       = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] LU_RELOAD = CW'(LU_STALL_CYC - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(MEM_TIMEOUT - 1);

  state_e         r_state;
  state_e         w_nxt_state;
  logic [CW-1:0]  r_wait_cnt;
  logic [CW-1:0]  w_nxt_cnt;
  logic [CW-1:0]  w_wait_base;
  logic           r_mem_err;
  logic           w_set_err;
  logic           w_br_flush;
  logic [1:0]     w_fwd_a;
  logic [1:0]     w_fwd_b;
  logic           w_lu_a;
  logic           w_lu_b;
  logic           w_ls;
  logic           w_unused_optype_id;

  // The ID op class belongs to the pipeline interface but no rule here depends on it.
  assign w_unused_optype_id = ^hazard_optype_ID;

  fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
    .i_rs           (rs1_ID),
    .i_use          (rs1use_ID),
    .i_rd_exe       (rd_EXE),
    .i_op_exe       (hazard_optype_EXE),
    .i_rd_mem       (rd_MEM),
    .i_op_mem       (hazard_optype_MEM),
    .o_sel          (w_fwd_a),
    .o_exe_load_hit (w_lu_a)
  );

  fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
    .i_rs           (rs2_ID),
    .i_use          (rs2use_ID),
    .i_rd_exe       (rd_EXE),
    .i_op_exe       (hazard_optype_EXE),
    .i_rd_mem       (rd_MEM),
    .i_op_mem       (hazard_optype_MEM),
    .o_sel          (w_fwd_b),
    .o_exe_load_hit (w_lu_b)
  );

  assign w_ls = store_EXE && (rs2_EXE != {REG_AW{1'b0}}) && (rs2_EXE == rd_MEM)
                && (hazard_optype_MEM == OP_LOAD);

  // Wait count only carries over while already waiting; LU_STALL uses the counter for bubbles.
  assign w_wait_base = (r_state == ST_MEM_WAIT) ? r_wait_cnt : CNT_ZERO;

  // Control outputs and next state, in strict priority order.
  always_comb begin
    {PC_EN_IF, reg_FD_EN, reg_DE_EN, reg_EM_EN, reg_MW_EN} = 5'b11111;
    {reg_FD_flush, reg_DE_flush, reg_EM_flush}               = 3'b000;
    forward_ctrl_A  = w_fwd_a;
    forward_ctrl_B  = w_fwd_b;
    forward_ctrl_ls = w_ls;
    w_nxt_state     = r_state;
    w_nxt_cnt       = r_wait_cnt;
    w_set_err       = 1'b0;
    w_br_flush      = 1'b0;
    if (rst || (r_state == ST_ERR)) begin
      {PC_EN_IF, reg_FD_EN, reg_DE_EN, reg_EM_EN, reg_MW_EN, reg_FD_flush, reg_DE_flush,
       reg_EM_flush, forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls} = 13'b0;
    end else if (!mem_ready) begin
      {PC_EN_IF, reg_FD_EN, reg_DE_EN, reg_EM_EN, reg_MW_EN, reg_FD_flush, reg_DE_flush,
       reg_EM_flush, forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls} = 13'b0;
      if (w_wait_base == TO_LAST) begin
        w_nxt_state = ST_ERR;
        w_set_err   = 1'b1;
      end else begin
        w_nxt_state = ST_MEM_WAIT;
        w_nxt_cnt   = w_wait_base + CNT_ONE;
      end
    end else if (branch_taken_EXE) begin
      reg_FD_flush = 1'b1;
      reg_DE_flush = 1'b1;
      w_br_flush   = 1'b1;
      w_nxt_state  = ST_RUN;
      w_nxt_cnt    = CNT_ZERO;
    end else if (r_state == ST_LU_STALL) begin
      PC_EN_IF     = 1'b0;
      reg_FD_EN    = 1'b0;
      reg_DE_flush = 1'b1;
      reg_EM_flush = (hazard_optype_EXE != OP_LOAD);
      if (r_wait_cnt <= CNT_ONE) begin
        w_nxt_state = ST_RUN;
        w_nxt_cnt   = CNT_ZERO;
      end else begin
        w_nxt_state = ST_LU_STALL;
        w_nxt_cnt   = r_wait_cnt - CNT_ONE;
      end
    end else if (w_lu_a || w_lu_b) begin
      PC_EN_IF     = 1'b0;
      reg_FD_EN    = 1'b0;
      reg_DE_flush = 1'b1;
      if (LU_STALL_CYC > 1) begin
        w_nxt_state = ST_LU_STALL;
        w_nxt_cnt   = LU_RELOAD;
      end else begin
        w_nxt_state = ST_RUN;
        w_nxt_cnt   = CNT_ZERO;
      end
    end else begin
      w_nxt_state = ST_RUN;
      w_nxt_cnt   = CNT_ZERO;
    end
  end

  // State, wait counter and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= CNT_ZERO;
      r_mem_err  <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_wait_cnt <= w_nxt_cnt;
      r_mem_err  <= r_mem_err | w_set_err;
    end
  end

  assign mem_err = r_mem_err;

`ifdef HAZ_PERF_CNT_EN
  localparam logic [CNT_W-1:0] PC_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] PC_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Saturating counts of fetch-stalled cycles and taken-branch flush cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= {CNT_W{1'b0}};
      r_flush_cnt <= {CNT_W{1'b0}};
    end else begin
      if (!PC_EN_IF && (r_stall_cnt != PC_MAX)) begin
        r_stall_cnt <= r_stall_cnt + PC_ONE;
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
      if (w_br_flush && (r_flush_cnt != PC_MAX)) begin
        r_flush_cnt <= r_flush_cnt + PC_ONE;
      end else begin
        r_flush_cnt <= r_flush_cnt;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  localparam int lp_unused_cnt_w = CNT_W;
  logic w_unused_br_flush;
  assign w_unused_br_flush = w_br_flush;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: directed scenarios plus randomized traffic
// compared against a cycle-level reference model of the hazard rules.
module tb_hazard_ctrl_unit;

  localparam int AW = 5;
  localparam int LU = 2;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] rs1_ID, rs2_ID, rd_EXE, rd_MEM, rs2_EXE;
  logic          rs1use_ID, rs2use_ID, store_EXE, branch_taken_EXE, mem_ready;
  logic [1:0]    hazard_optype_ID, hazard_optype_EXE, hazard_optype_MEM;
  logic          PC_EN_IF, reg_FD_EN, reg_DE_EN, reg_EM_EN, reg_MW_EN;
  logic          reg_FD_flush, reg_DE_flush, reg_EM_flush;
  logic [1:0]    forward_ctrl_A, forward_ctrl_B;
  logic          forward_ctrl_ls, mem_err;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0]   stall_cnt, flush_cnt;
`endif
  logic [13:0]   w_obs;

  int n_checks = 0;
  int n_pass   = 0;
  int m_stall_left = 0;
  int m_wait = 0;
  bit m_err = 1'b0;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.REG_AW(AW), .LU_STALL_CYC(LU), .MEM_TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rs1use_ID(rs1use_ID), .rs2use_ID(rs2use_ID),
    .hazard_optype_ID(hazard_optype_ID), .hazard_optype_EXE(hazard_optype_EXE),
    .hazard_optype_MEM(hazard_optype_MEM), .rd_EXE(rd_EXE), .rd_MEM(rd_MEM),
    .rs2_EXE(rs2_EXE), .store_EXE(store_EXE), .branch_taken_EXE(branch_taken_EXE),
    .mem_ready(mem_ready), .PC_EN_IF(PC_EN_IF), .reg_FD_EN(reg_FD_EN), .reg_DE_EN(reg_DE_EN),
    .reg_EM_EN(reg_EM_EN), .reg_MW_EN(reg_MW_EN), .reg_FD_flush(reg_FD_flush),
    .reg_DE_flush(reg_DE_flush), .reg_EM_flush(reg_EM_flush),
    .forward_ctrl_A(forward_ctrl_A), .forward_ctrl_B(forward_ctrl_B),
    .forward_ctrl_ls(forward_ctrl_ls), .mem_err(mem_err)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  assign w_obs = {PC_EN_IF, reg_FD_EN, reg_DE_EN, reg_EM_EN, reg_MW_EN,
                  reg_FD_flush, reg_DE_flush, reg_EM_flush,
                  forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls, mem_err};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference forward choice: youngest ALU/load producer with a matching nonzero source.
  function automatic logic [1:0] ref_fwd(input logic used, input logic [AW-1:0] rs);
    logic live;
    live = used && (rs != 0);
    if (live && rs == rd_EXE && hazard_optype_EXE == 2'd1) return 2'd1;
    if (live && rs == rd_MEM && hazard_optype_MEM == 2'd1) return 2'd2;
    if (live && rs == rd_MEM && hazard_optype_MEM == 2'd2) return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic ref_load_use(input logic used, input logic [AW-1:0] rs);
    return used && (rs != 0) && (rs == rd_EXE) && (hazard_optype_EXE == 2'd2);
  endfunction

  task automatic model_clear();
    m_stall_left = 0;
    m_wait = 0;
    m_err = 1'b0;
  endtask

  // Compare this cycle's outputs with the model, then advance the model across the coming edge.
  task automatic sample_check(input string tag);
    logic [4:0]  en;
    logic [2:0]  fl;
    logic [1:0]  fa, fb;
    logic        ls, lu, old_err;
    #4;
    old_err = m_err;
    fa = ref_fwd(rs1use_ID, rs1_ID);
    fb = ref_fwd(rs2use_ID, rs2_ID);
    ls = store_EXE && rs2_EXE != 0 && rs2_EXE == rd_MEM && hazard_optype_MEM == 2'd2;
    lu = ref_load_use(rs1use_ID, rs1_ID) || ref_load_use(rs2use_ID, rs2_ID);
    en = 5'b11111;
    fl = 3'b000;
    if (m_err) begin
      en = 5'b0; fa = 2'd0; fb = 2'd0; ls = 1'b0;
    end else if (!mem_ready) begin
      en = 5'b0; fa = 2'd0; fb = 2'd0; ls = 1'b0;
      m_stall_left = 0;
      m_wait++;
      if (m_wait >= TO) m_err = 1'b1;
    end else begin
      m_wait = 0;
      if (branch_taken_EXE) begin
        fl = 3'b110;
        m_stall_left = 0;
      end else if (m_stall_left > 0) begin
        en[4:3] = 2'b00;
        fl = {1'b0, 1'b1, hazard_optype_EXE != 2'd2};
        m_stall_left--;
      end else if (lu) begin
        en[4:3] = 2'b00;
        fl = 3'b010;
        m_stall_left = LU - 1;
      end
    end
    check_eq(tag, {18'd0, w_obs}, {18'd0, en, fl, fa, fb, ls, old_err});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs1_ID = '0; rs2_ID = '0; rs1use_ID = 1'b0; rs2use_ID = 1'b0;
    hazard_optype_ID = 2'd0; hazard_optype_EXE = 2'd0; hazard_optype_MEM = 2'd0;
    rd_EXE = '0; rd_MEM = '0; rs2_EXE = '0; store_EXE = 1'b0;
    branch_taken_EXE = 1'b0; mem_ready = 1'b1;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check_eq(tag, {18'd0, w_obs}, 32'd0);
`ifdef HAZ_PERF_CNT_EN
    check_eq("perf_stall_rst", stall_cnt, 32'd0);
    check_eq("perf_flush_rst", flush_cnt, 32'd0);
`endif
    tick();
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    idle();
    #1;
    do_reset("reset_outs");

    // Forwarding priority and x0
    hazard_optype_EXE = 2'd1; rd_EXE = 5'd5; hazard_optype_MEM = 2'd1; rd_MEM = 5'd5;
    rs1_ID = 5'd5; rs1use_ID = 1'b1;
    sample_check("fwd_exe_pri"); check_eq("fwdA_exe", forward_ctrl_A, 32'd1);
    check_eq("fwd_no_stall", PC_EN_IF, 32'd1); tick();
    rs1_ID = 5'd0;
    sample_check("fwd_x0"); check_eq("fwdA_x0", forward_ctrl_A, 32'd0); tick();
    rs1_ID = 5'd5; hazard_optype_EXE = 2'd0;
    sample_check("fwd_mem_alu"); check_eq("fwdA_mem", forward_ctrl_A, 32'd2); tick();
    hazard_optype_MEM = 2'd2;
    sample_check("fwd_mem_ld"); check_eq("fwdA_ld", forward_ctrl_A, 32'd3); tick();

    // Load-use with two bubbles
    idle(); hazard_optype_EXE = 2'd2; rd_EXE = 5'd7; rs2_ID = 5'd7; rs2use_ID = 1'b1;
    sample_check("lu_c1"); check_eq("lu_c1_pc", PC_EN_IF, 32'd0);
    check_eq("lu_c1_de", reg_DE_flush, 32'd1); tick();
    hazard_optype_EXE = 2'd0; hazard_optype_MEM = 2'd2; rd_MEM = 5'd7;
    sample_check("lu_c2"); check_eq("lu_c2_pc", PC_EN_IF, 32'd0);
    check_eq("lu_c2_em", reg_EM_flush, 32'd1); tick();
    sample_check("lu_done"); check_eq("lu_fwdB", forward_ctrl_B, 32'd3);
    check_eq("lu_done_pc", PC_EN_IF, 32'd1); tick();

    // Short memory wait
    idle(); hazard_optype_MEM = 2'd2; rd_MEM = 5'd3; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample_check("mw_freeze");
      check_eq("mw_en", {PC_EN_IF, reg_FD_EN, reg_DE_EN, reg_EM_EN, reg_MW_EN}, 32'd0);
      tick();
    end
    mem_ready = 1'b1;
    sample_check("mw_resume"); check_eq("mw_resume_pc", PC_EN_IF, 32'd1);
    check_eq("mw_no_err", mem_err, 32'd0); tick();

    // Branch beats load-use
    idle(); hazard_optype_EXE = 2'd2; rd_EXE = 5'd7; rs2_ID = 5'd7; rs2use_ID = 1'b1;
    branch_taken_EXE = 1'b1;
    sample_check("br_lu"); check_eq("br_flags", {reg_FD_flush, reg_DE_flush, PC_EN_IF}, 32'd7);
    tick();
    branch_taken_EXE = 1'b0; hazard_optype_EXE = 2'd0;
    sample_check("br_no_lustall"); check_eq("br_after_pc", PC_EN_IF, 32'd1); tick();

    // Load-to-store forwarding
    idle(); store_EXE = 1'b1; rs2_EXE = 5'd9; hazard_optype_MEM = 2'd2; rd_MEM = 5'd9;
    sample_check("ls_hit"); check_eq("ls_one", forward_ctrl_ls, 32'd1); tick();
    rd_MEM = 5'd0;
    sample_check("ls_rd0"); check_eq("ls_zero", forward_ctrl_ls, 32'd0); tick();

    // Timeout into sticky error
    idle(); hazard_optype_MEM = 2'd2; mem_ready = 1'b0;
    for (int i = 0; i < TO; i++) begin
      sample_check("to_wait");
      tick();
    end
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample_check("err_hold"); check_eq("err_flag", mem_err, 32'd1);
      check_eq("err_pc", PC_EN_IF, 32'd0); tick();
    end
    do_reset("err_reset");
    sample_check("err_cleared"); check_eq("err_clr_flag", mem_err, 32'd0); tick();

    // Asynchronous reset in the middle of a wait
    idle(); hazard_optype_MEM = 2'd2; mem_ready = 1'b0;
    sample_check("arst_w1"); tick();
    sample_check("arst_w2");
    #2;
    rst = 1'b1;
    #1;
    check_eq("rst_async", {18'd0, w_obs}, 32'd0);
`ifdef HAZ_PERF_CNT_EN
    check_eq("perf_async_rst", stall_cnt, 32'd0);
`endif
    tick();
    rst = 1'b0;
    model_clear();
    idle();
    sample_check("post_rst"); tick();

    // Randomized traffic over a small register space so matches are frequent
    for (int i = 0; i < 800; i++) begin
      rs1_ID = AW'($urandom_range(0, 3));
      rs2_ID = AW'($urandom_range(0, 3));
      rs1use_ID = 1'($urandom_range(0, 1));
      rs2use_ID = 1'($urandom_range(0, 1));
      hazard_optype_ID = 2'($urandom_range(0, 3));
      hazard_optype_EXE = 2'($urandom_range(0, 3));
      hazard_optype_MEM = 2'($urandom_range(0, 3));
      rd_EXE = AW'($urandom_range(0, 3));
      rd_MEM = AW'($urandom_range(0, 3));
      rs2_EXE = AW'($urandom_range(0, 3));
      store_EXE = 1'($urandom_range(0, 1));
      branch_taken_EXE = ($urandom_range(0, 5) == 0);
      mem_ready = (hazard_optype_MEM == 2'd2) ? ($urandom_range(0, 4) != 0) : 1'b1;
      sample_check("rand");
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
